// File: rtl/mem_stage_pkg.sv
// Shared widths, memory-op encodings and MEM/WB register layout for the memory-access stage.
package mem_stage_pkg;

    localparam int PC_WIDTH          = 32;
    localparam int WORD_WIDTH        = 32;
    localparam int GPR_ADDR_WIDTH    = 5;
    localparam int DATA_WIDTH_MEM_OP = 4;

    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_NOP = 4'd0;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LB  = 4'd1;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LH  = 4'd2;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LW  = 4'd3;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LBU = 4'd4;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LHU = 4'd5;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SB  = 4'd6;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SH  = 4'd7;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SW  = 4'd8;

    typedef struct packed {
        logic [PC_WIDTH-1:0]       pc;
        logic [31:0]               insn;
        logic                      en;
        logic                      gpr_we_;
        logic [GPR_ADDR_WIDTH-1:0] dst_addr;
        logic [WORD_WIDTH-1:0]     out;
    } memwb_t;

    // A bubble never writes the register file, so the active-low enable sits at 1.
    localparam memwb_t MEMWB_BUBBLE = '{pc: '0, insn: '0, en: 1'b0, gpr_we_: 1'b1,
                                        dst_addr: '0, out: '0};

    function automatic logic op_is_store(input logic [DATA_WIDTH_MEM_OP-1:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic op_misaligned(input logic [DATA_WIDTH_MEM_OP-1:0] op,
                                           input logic [1:0] lsb);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return lsb[0];
            MEM_OP_LW, MEM_OP_SW:             return |lsb;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane of the bus word and extends it.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [DATA_WIDTH_MEM_OP-1:0] mem_op,
    input  logic [1:0]                   lane,
    input  logic [WORD_WIDTH-1:0]        rdata,
    output logic [WORD_WIDTH-1:0]        load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    function automatic logic [WORD_WIDTH-1:0] sext8(input logic signed [7:0] v);
        return WORD_WIDTH'(v);
    endfunction

    function automatic logic [WORD_WIDTH-1:0] sext16(input logic signed [15:0] v);
        return WORD_WIDTH'(v);
    endfunction

    function automatic logic [WORD_WIDTH-1:0] zext8(input logic [7:0] v);
        return WORD_WIDTH'(v);
    endfunction

    function automatic logic [WORD_WIDTH-1:0] zext16(input logic [15:0] v);
        return WORD_WIDTH'(v);
    endfunction

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (mem_op)
            MEM_OP_LB:  load_data = sext8(byte_sel);
            MEM_OP_LBU: load_data = zext8(byte_sel);
            MEM_OP_LH:  load_data = sext16(half_sel);
            MEM_OP_LHU: load_data = zext16(half_sel);
            default:    load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs one load/store at a time on the req/gnt/rvalid data bus and
// fills the MEM/WB register, stalling upstream while a transaction is in flight.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mem_flush,
    input  logic [PC_WIDTH-1:0]          ex_pc,
    input  logic [31:0]                  ex_insn,
    input  logic                         ex_en,
    input  logic [WORD_WIDTH-1:0]        ex_alu_out,
    input  logic                         ex_gpr_we_,
    input  logic [GPR_ADDR_WIDTH-1:0]    ex_dst_addr,
    input  logic [DATA_WIDTH_MEM_OP-1:0] ex_mem_op,
    input  logic [WORD_WIDTH-1:0]        ex_store_data,
    input  logic [3:0]                   ex_store_byteena,
    output logic                         mem_stall,
    output logic                         mem_misaligned,
    output logic                         dbus_req,
    output logic [WORD_WIDTH-1:0]        dbus_addr,
    output logic                         dbus_we,
    output logic [3:0]                   dbus_be,
    output logic [WORD_WIDTH-1:0]        dbus_wdata,
    input  logic                         dbus_gnt,
    input  logic                         dbus_rvalid,
    input  logic [WORD_WIDTH-1:0]        dbus_rdata,
    output logic [PC_WIDTH-1:0]          mem_pc,
    output logic [31:0]                  mem_insn,
    output logic                         mem_en,
    output logic                         mem_gpr_we_,
    output logic [GPR_ADDR_WIDTH-1:0]    mem_dst_addr,
    output logic [WORD_WIDTH-1:0]        mem_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

    state_t                state;
    logic                  drop;
    logic                  is_mem;
    logic                  is_store;
    logic                  misaligned;
    logic                  acc;
    logic                  acc_pending;
    logic                  rsp_done;
    logic [WORD_WIDTH-1:0] load_data;
    memwb_t                wb_q;
    memwb_t                wb_next;

    assign is_mem     = (ex_mem_op != MEM_OP_NOP);
    assign is_store   = op_is_store(ex_mem_op);
    assign misaligned = ex_en & is_mem & op_misaligned(ex_mem_op, ex_alu_out[1:0]);

    // Gated by rst_n so that request/stall read as idle for the whole reset window.
    assign acc         = rst_n & ex_en & is_mem & ~misaligned & ~mem_flush;
    assign rsp_done    = (state == ST_RESP) & dbus_rvalid;
    assign acc_pending = ((state == ST_IDLE) & acc) | (state != ST_IDLE);
    assign mem_stall   = acc_pending & ~rsp_done;

    assign mem_misaligned = rst_n & (state == ST_IDLE) & misaligned & ~mem_flush;

    assign dbus_req   = ((state == ST_IDLE) & acc) | (state == ST_REQ);
    assign dbus_addr  = {ex_alu_out[WORD_WIDTH-1:2], 2'b00};
    assign dbus_we    = is_store;
    assign dbus_be    = is_store ? ex_store_byteena : 4'b1111;
    assign dbus_wdata = ex_store_data;

    mem_stage_load_align u_load_align (
        .mem_op    (ex_mem_op),
        .lane      (ex_alu_out[1:0]),
        .rdata     (dbus_rdata),
        .load_data (load_data)
    );

    // A flush seen after the grant cannot cancel the bus cycle; drop remembers to discard it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            drop  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    drop <= 1'b0;
                    if (acc) begin
                        state <= dbus_gnt ? ST_RESP : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dbus_gnt) begin
                        state <= ST_RESP;
                        drop  <= mem_flush;
                    end else if (mem_flush) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (dbus_rvalid) begin
                        state <= ST_IDLE;
                        drop  <= 1'b0;
                    end else if (mem_flush) begin
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    drop  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wb_next = MEMWB_BUBBLE;
        if (!(mem_stall | mem_flush)) begin
            if (rsp_done) begin
                if (!drop) begin
                    wb_next.pc       = ex_pc;
                    wb_next.insn     = ex_insn;
                    wb_next.en       = ex_en;
                    wb_next.gpr_we_  = is_store ? 1'b1 : ex_gpr_we_;
                    wb_next.dst_addr = ex_dst_addr;
                    wb_next.out      = is_store ? ex_alu_out : load_data;
                end
            end else if (!misaligned) begin
                wb_next.pc       = ex_pc;
                wb_next.insn     = ex_insn;
                wb_next.en       = ex_en;
                wb_next.gpr_we_  = ex_gpr_we_;
                wb_next.dst_addr = ex_dst_addr;
                wb_next.out      = ex_alu_out;
            end
        end
    end

    // MEM/WB pipeline register boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= MEMWB_BUBBLE;
        end else begin
            wb_q <= wb_next;
        end
    end

    assign mem_pc       = wb_q.pc;
    assign mem_insn     = wb_q.insn;
    assign mem_en       = wb_q.en;
    assign mem_gpr_we_  = wb_q.gpr_we_;
    assign mem_dst_addr = wb_q.dst_addr;
    assign mem_out      = wb_q.out;

endmodule
